// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg: shared state encoding and default sizing for booth_mult_scheduler.
package booth_sched_pkg;

    localparam int STATE_W   = 3;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set req at or above ptr (mod NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    logic [NREQ-1:0] rot_req;
    logic [NREQ-1:0] rot_gnt;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
    assign rot_req = NREQ'({req, req} >> ptr);
    assign rot_gnt = rot_req & (~rot_req + NREQ'(1));
    assign gnt     = NREQ'(({rot_gnt, rot_gnt} << ptr) >> NREQ);

endmodule

// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler: round-robin sharing of one sequential Booth datapath between NREQ clients.
// Optional BOOTH_SCHED_STATS_EN adds the ops_done completion counter.
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_prod,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_load,
    output logic                  mul_rst,
    input  logic [2*WIDTH-1:0]    mul_prod
`ifdef BOOTH_SCHED_STATS_EN
   ,output logic [15:0]           ops_done
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH);

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   rsp_prod_q, rsp_prod_d;
    logic [NREQ-1:0]      gnt;
    logic [PW-1:0]        win_idx;
    logic [WIDTH-1:0]     win_a, win_b;
`ifdef BOOTH_SCHED_STATS_EN
    logic [15:0]          ops_q, ops_d;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_idx = '0;
        win_a   = '0;
        win_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx = PW'(i);
                win_a   = req_a[i*WIDTH +: WIDTH];
                win_b   = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_prod_d = rsp_prod_q;
`ifdef BOOTH_SCHED_STATS_EN
        ops_d      = ops_q;
`endif
        req_ready  = '0;
        rsp_valid  = '0;
        mul_load   = 1'b0;
        mul_rst    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = gnt;
                mul_rst   = 1'b1;
                if (|(req_valid & gnt)) begin
                    grant_d = win_idx;
                    mul_a_d = win_a;
                    mul_b_d = win_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mul_load = 1'b1;
                cnt_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH-1)) ? S_CAPT : S_RUN;
            end
            // The datapath holds its final product here; clearing it on this edge is safe.
            S_CAPT: begin
                mul_rst    = 1'b1;
                rsp_prod_d = mul_prod;
                state_d    = S_RESP;
            end
            S_RESP: begin
                mul_rst   = 1'b1;
                rsp_valid = NREQ'(1) << grant_q;
                if (|(rsp_ready & rsp_valid)) begin
                    rr_ptr_d = (grant_q == PW'(NREQ-1)) ? '0 : grant_q + PW'(1);
                    state_d  = S_IDLE;
`ifdef BOOTH_SCHED_STATS_EN
                    ops_d    = ops_q + 16'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_prod_q <= '0;
`ifdef BOOTH_SCHED_STATS_EN
            ops_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_prod_q <= rsp_prod_d;
`ifdef BOOTH_SCHED_STATS_EN
            ops_q      <= ops_d;
`endif
        end
    end

    assign rsp_prod = rsp_prod_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
`ifdef BOOTH_SCHED_STATS_EN
    assign ops_done = ops_q;
`endif

endmodule
